uart_cmd_master: RTL and testbench

- Host-side command initiator for the UART-controlled system.
- Accepts one command at a time over a valid/ready request port.
- Serialises the command into the byte frame that the system controller decodes: register-file write, register-file read, ALU with operands, and ALU without operands.
- Pushes those bytes into a UART transmitter, then reassembles the response bytes from a UART receiver into one result word.
- Used in the top-level testbench and in an FPGA host bridge, on the UART side of the link.

---
 rtl/uart_cmd_pkg.sv | 34 +++
 rtl/uart_cmd_master_if.sv | 29 ++
 rtl/uart_cmd_rsp_timer.sv | 18 +
 rtl/uart_cmd_master.sv | 102 ++++++++++
 tb/tb_uart_cmd_master.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command encodings, frame opcodes, frame lengths and FSM states for uart_cmd_master
package uart_cmd_pkg;
  typedef enum logic [1:0] {
    RF_WR   = 2'd0,
    RF_RD   = 2'd1,
    ALU_OP  = 2'd2,
    ALU_NOP = 2'd3
  } cmd_type_e;
  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;
  localparam logic [2:0] TX_LEN_RF_WR   = 3'd3;
  localparam logic [2:0] TX_LEN_RF_RD   = 3'd2;
  localparam logic [2:0] TX_LEN_ALU_OP  = 3'd4;
  localparam logic [2:0] TX_LEN_ALU_NOP = 3'd2;
  localparam logic [1:0] RX_LEN_RF_WR   = 2'd0;
  localparam logic [1:0] RX_LEN_RF_RD   = 2'd1;
  localparam logic [1:0] RX_LEN_ALU_OP  = 2'd2;
  localparam logic [1:0] RX_LEN_ALU_NOP = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  function automatic logic [7:0] opcode(cmd_type_e t);
    return t == RF_WR ? OP_RF_WR : t == RF_RD ? OP_RF_RD : t == ALU_OP ? OP_ALU_OP : OP_ALU_NOP;
  endfunction
  function automatic logic [2:0] tx_len(cmd_type_e t);
    return t == RF_WR ? TX_LEN_RF_WR : t == RF_RD ? TX_LEN_RF_RD : t == ALU_OP ? TX_LEN_ALU_OP : TX_LEN_ALU_NOP;
  endfunction
  function automatic logic [1:0] rx_len(cmd_type_e t);
    return t == RF_WR ? RX_LEN_RF_WR : t == RF_RD ? RX_LEN_RF_RD : t == ALU_OP ? RX_LEN_ALU_OP : RX_LEN_ALU_NOP;
  endfunction
endpackage

// File: rtl/uart_cmd_master_if.sv
// uart_cmd_master_if: command request, UART byte streams and response bundle
interface uart_cmd_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4
);
  logic                    cmd_vld;
  logic                    cmd_rdy;
  logic [1:0]              cmd_type;
  logic [RF_ADDR-1:0]      cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data_a;
  logic [DATA_WIDTH-1:0]   cmd_data_b;
  logic [3:0]              cmd_fun;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_vld;
  logic                    tx_rdy;
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_vld;
  logic [2*DATA_WIDTH-1:0] rsp_data;
  logic                    rsp_vld;
  logic                    rsp_err;
  modport master (
    input  cmd_vld, cmd_type, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun, tx_rdy, rx_data, rx_vld,
    output cmd_rdy, tx_data, tx_vld, rsp_data, rsp_vld, rsp_err
  );
  modport slave (
    output cmd_vld, cmd_type, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun, tx_rdy, rx_data, rx_vld,
    input  cmd_rdy, tx_data, tx_vld, rsp_data, rsp_vld, rsp_err
  );
endinterface

// File: rtl/uart_cmd_rsp_timer.sv
// uart_cmd_rsp_timer: 16-bit response timeout counter; expire fires on the cycle the count reaches TIMEOUT_CYCLES
module uart_cmd_rsp_timer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [15:0] cnt;
  // count enabled cycles, restarting whenever cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? 16'd0 : en ? cnt + 16'd1 : cnt;
  end
  assign expire = en && !clr && cnt == 16'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: serialises commands to UART TX bytes and assembles RX response bytes; UART_CMD_TIMEOUT_EN adds a response timeout
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int RF_ADDR        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic               clk,
  input logic               rst_n,
  uart_cmd_master_if.master bus
);
  localparam int DW = DATA_WIDTH;
  logic [1:0]    state;
  cmd_type_e     typ;
  logic [DW-1:0] addr_b, data_a, data_b, fun_b, next_byte;
  logic [1:0]    idx, rx_idx;
  logic          last_tx, last_rx, expire;
  // frame byte following the one currently on TX, taken from the captured command
  always_comb begin
    next_byte = idx == 2'd0 ? (typ == ALU_OP ? data_a : typ == ALU_NOP ? fun_b : addr_b) :
                idx == 2'd1 ? (typ == ALU_OP ? data_b : data_a) : fun_b;
  end
  assign last_tx = {1'b0, idx} == tx_len(typ) - 3'd1;
  assign last_rx = rx_idx + 2'd1 == rx_len(typ);
`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_rsp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != ST_WAIT || bus.rx_vld),
    .en     (state == ST_WAIT),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif
  // command FSM: accept, send frame, collect response, strobe result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      typ          <= RF_WR;
      addr_b       <= '0;
      data_a       <= '0;
      data_b       <= '0;
      fun_b        <= '0;
      idx          <= '0;
      rx_idx       <= '0;
      bus.cmd_rdy  <= 1'b1;
      bus.tx_vld   <= 1'b0;
      bus.tx_data  <= '0;
      bus.rsp_vld  <= 1'b0;
      bus.rsp_err  <= 1'b0;
      bus.rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.cmd_vld) begin
          typ          <= cmd_type_e'(bus.cmd_type);
          addr_b       <= DW'(bus.cmd_addr);
          data_a       <= bus.cmd_data_a;
          data_b       <= bus.cmd_data_b;
          fun_b        <= DW'(bus.cmd_fun);
          idx          <= '0;
          rx_idx       <= '0;
          bus.rsp_data <= '0;
          bus.cmd_rdy  <= 1'b0;
          bus.tx_vld   <= 1'b1;
          bus.tx_data  <= DW'(opcode(cmd_type_e'(bus.cmd_type)));
          state        <= ST_SEND;
        end
        ST_SEND: if (bus.tx_rdy) begin
          idx         <= idx + 2'd1;
          bus.tx_data <= next_byte;
          if (last_tx) begin
            bus.tx_vld <= 1'b0;
            state      <= rx_len(typ) == 2'd0 ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: if (bus.rx_vld) begin
          bus.rsp_data[rx_idx[0]*DW +: DW] <= bus.rx_data;
          rx_idx <= rx_idx + 2'd1;
          if (last_rx) begin
            bus.rsp_vld <= 1'b1;
            bus.rsp_err <= 1'b0;
            state       <= ST_DONE;
          end
        end else if (expire) begin
          bus.rsp_vld <= 1'b1;
          bus.rsp_err <= 1'b1;
          state       <= ST_DONE;
        end
        default: if (bus.rsp_vld) begin
          bus.rsp_vld <= 1'b0;
          bus.cmd_rdy <= 1'b1;
          state       <= ST_IDLE;
        end else begin
          bus.rsp_vld <= 1'b1;
          bus.rsp_err <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: randomized and directed checks of uart_cmd_master against a frame/response model
module tb_uart_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  uart_cmd_master_if #(.DATA_WIDTH(8), .RF_ADDR(4)) bus ();
  uart_cmd_master #(.DATA_WIDTH(8), .RF_ADDR(4), .TIMEOUT_CYCLES(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rdy;
    int n = 0;
    while (!bus.cmd_rdy && n < 50) begin
      tick;
      n++;
    end
    chk("cmd_rdy_wait", 32'(bus.cmd_rdy), 1);
  endtask
  // mode: 0 = TX always ready, 1 = ready toggling 1/0, 2 = random ready
  task automatic run_cmd(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] f, input int mode, input bit stray, input logic [7:0] r0,
                         input logic [7:0] r1, input bit no_rx);
    logic [7:0] q[$];
    logic [7:0] prev;
    logic [15:0] rsp;
    bit held;
    bit rdy;
    int rxn;
    int n;
    case (t)
      2'd0: q = '{8'hAA, {4'h0, ad}, a};
      2'd1: q = '{8'hBB, {4'h0, ad}};
      2'd2: q = '{8'hCC, a, b, {4'h0, f}};
      default: q = '{8'hDD, {4'h0, f}};
    endcase
    rxn = t == 2'd0 ? 0 : t == 2'd1 ? 1 : 2;
    rsp = '0;
    wait_rdy;
    bus.cmd_vld = 1'b1;
    bus.cmd_type = t;
    bus.cmd_addr = ad;
    bus.cmd_data_a = a;
    bus.cmd_data_b = b;
    bus.cmd_fun = f;
    tick;
    chk("tx_first_vld", 32'(bus.tx_vld), 1);
    chk("cmd_rdy_busy", 32'(bus.cmd_rdy), 0);
    held = 1'b0;
    prev = '0;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      chk("tx_vld", 32'(bus.tx_vld), 1);
      if (held) chk("tx_hold", 32'(bus.tx_data), 32'(prev));
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (n % 2 == 0) : 1'($urandom);
      bus.tx_rdy = rdy;
      bus.rx_vld = stray && ($urandom % 3 == 0);
      bus.rx_data = 8'($urandom);
      bus.cmd_vld = 1'($urandom);
      bus.cmd_type = 2'($urandom);
      bus.cmd_addr = 4'($urandom);
      bus.cmd_data_a = 8'($urandom);
      bus.cmd_data_b = 8'($urandom);
      bus.cmd_fun = 4'($urandom);
      if (rdy) chk("tx_byte", 32'(bus.tx_data), 32'(q.pop_front()));
      held = !rdy;
      prev = bus.tx_data;
      tick;
      n++;
    end
    chk("tx_all_sent", q.size(), 0);
    bus.cmd_vld = 1'b0;
    bus.rx_vld = 1'b0;
    bus.tx_rdy = 1'($urandom);
    chk("tx_idle", 32'(bus.tx_vld), 0);
    if (no_rx) begin
      n = 0;
      while (!bus.rsp_vld && n < 300) begin
        tick;
        n++;
      end
      chk("timeout_latency", n, 100);
      chk("timeout_err", 32'(bus.rsp_err), 1);
      chk("timeout_data", 32'(bus.rsp_data), 0);
      tick;
      chk("timeout_strobe_once", 32'(bus.rsp_vld), 0);
      chk("err_hold", 32'(bus.rsp_err), 1);
      chk("cmd_rdy_after_timeout", 32'(bus.cmd_rdy), 1);
      return;
    end
    if (rxn == 0) begin
      chk("rsp_early", 32'(bus.rsp_vld), 0);
      tick;
    end
    for (int i = 0; i < rxn; i++) begin
      repeat ($urandom % 4) begin
        chk("rsp_early", 32'(bus.rsp_vld), 0);
        tick;
      end
      chk("rsp_early", 32'(bus.rsp_vld), 0);
      bus.rx_vld = 1'b1;
      bus.rx_data = i == 0 ? r0 : r1;
      rsp[8*i +: 8] = bus.rx_data;
      tick;
      bus.rx_vld = 1'b0;
    end
    chk("rsp_vld", 32'(bus.rsp_vld), 1);
    chk("rsp_data", 32'(bus.rsp_data), 32'(rsp));
    chk("rsp_err", 32'(bus.rsp_err), 0);
    chk("cmd_rdy_in_rsp", 32'(bus.cmd_rdy), 0);
    tick;
    chk("rsp_strobe_once", 32'(bus.rsp_vld), 0);
    chk("cmd_rdy_after_rsp", 32'(bus.cmd_rdy), 1);
  endtask
  initial begin
    bus.cmd_vld = 1'b0;
    bus.cmd_type = '0;
    bus.cmd_addr = '0;
    bus.cmd_data_a = '0;
    bus.cmd_data_b = '0;
    bus.cmd_fun = '0;
    bus.tx_rdy = 1'b0;
    bus.rx_data = '0;
    bus.rx_vld = 1'b0;
    repeat (3) tick;
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 1);
    chk("rst_tx_vld", 32'(bus.tx_vld), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_rsp_vld", 32'(bus.rsp_vld), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    rst_n = 1'b1;
    tick;
    run_cmd(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    run_cmd(2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 1, 1'b0, 8'h81, 8'h00, 1'b0);
    run_cmd(2'd2, 4'd0, 8'h12, 8'h34, 4'd1, 0, 1'b0, 8'h46, 8'h00, 1'b0);
    run_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'd2, 2, 1'b1, 8'h78, 8'h56, 1'b0);
`ifdef UART_CMD_TIMEOUT_EN
    run_cmd(2'd1, 4'd5, 8'h00, 8'h00, 4'd0, 0, 1'b0, 8'h00, 8'h00, 1'b1);
`endif
    wait_rdy;
    bus.cmd_vld = 1'b1;
    bus.cmd_type = 2'd2;
    bus.cmd_data_a = 8'h9A;
    bus.cmd_data_b = 8'hBC;
    bus.cmd_fun = 4'd7;
    bus.tx_rdy = 1'b1;
    tick;
    bus.cmd_vld = 1'b0;
    tick;
    tick;
    chk("pre_rst_byte", 32'(bus.tx_data), 32'h00BC);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_vld", 32'(bus.tx_vld), 0);
    chk("mid_rst_cmd_rdy", 32'(bus.cmd_rdy), 1);
    chk("mid_rst_rsp_vld", 32'(bus.rsp_vld), 0);
    tick;
    tick;
    rst_n = 1'b1;
    bus.tx_rdy = 1'b0;
    repeat (6) begin
      tick;
      chk("post_rst_quiet", {30'd0, bus.rsp_vld, bus.tx_vld}, 0);
    end
    run_cmd(2'd1, 4'd9, 8'h00, 8'h00, 4'd0, 2, 1'b1, 8'h3C, 8'h00, 1'b0);
    repeat (40) begin
      run_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
              int'($urandom % 3), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
